// File: rtl/pe_link_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : pe_link_endpoint
// Description : PE-to-router link endpoint: FWFT receive FIFO, 2-entry transmit
//               skid buffer and transmitted-word counter.
// Revision    : 1.0
// ============================================================================
module pe_link_endpoint #(
    parameter int RX_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [63:0]                 link_in_data,
    input  logic                        link_in_valid,
    output logic                        link_in_accept,
    output logic [63:0]                 link_out_data,
    output logic                        link_out_valid,
    input  logic                        link_out_accept,
    output logic [63:0]                 pe_rd_data,
    output logic                        pe_rd_valid,
    input  logic                        pe_rd_en,
    input  logic [63:0]                 pe_wr_data,
    input  logic                        pe_wr_valid,
    output logic                        pe_wr_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [CNT_W-1:0]            tx_words
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        TX_EMPTY = 2'd0,
        TX_ONE   = 2'd1,
        TX_TWO   = 2'd2
    } tx_state_t;

    // ---------------- receive FIFO ----------------
    logic [63:0]   rx_mem [RX_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_alive;
    logic          w_push;
    logic          w_pop;

    // r_alive holds accept low through reset and the edge that releases it
    assign link_in_accept = r_alive && (r_level < LW'(RX_DEPTH));
    assign pe_rd_valid    = (r_level != '0);
    assign pe_rd_data     = rx_mem[r_rd_ptr];
    assign rx_level       = r_level;
    assign w_push         = link_in_valid & link_in_accept;
    assign w_pop          = pe_rd_en & pe_rd_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            rx_mem[r_wr_ptr] <= link_in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alive  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------- transmit skid buffer ----------------
    tx_state_t     r_state;
    tx_state_t     w_state_nxt;
    logic [63:0]   r_buf0;
    logic [63:0]   r_buf1;
    logic [63:0]   w_buf0_nxt;
    logic [63:0]   w_buf1_nxt;
    logic          r_out_valid;
    logic          r_wr_ready;
    logic [CNT_W-1:0] r_tx_words;
    logic          w_wr;
    logic          w_xfer;

    assign w_wr           = pe_wr_valid & r_wr_ready;
    assign w_xfer         = r_out_valid & link_out_accept;
    assign pe_wr_ready    = r_wr_ready;
    assign link_out_valid = r_out_valid;
    assign link_out_data  = r_buf0;
    assign tx_words       = r_tx_words;

    always_comb begin
        w_state_nxt = r_state;
        w_buf0_nxt  = r_buf0;
        w_buf1_nxt  = r_buf1;
        case (r_state)
            TX_EMPTY: begin
                if (w_wr) begin
                    w_buf0_nxt  = pe_wr_data;
                    w_state_nxt = TX_ONE;
                end
            end
            TX_ONE: begin
                if (w_wr && w_xfer) begin
                    w_buf0_nxt = pe_wr_data;
                end else if (w_wr) begin
                    w_buf1_nxt  = pe_wr_data;
                    w_state_nxt = TX_TWO;
                end else if (w_xfer) begin
                    w_state_nxt = TX_EMPTY;
                end
            end
            TX_TWO: begin
                if (w_xfer) begin
                    w_buf0_nxt  = r_buf1;
                    w_state_nxt = TX_ONE;
                end
            end
            default: w_state_nxt = TX_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= TX_EMPTY;
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_out_valid <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_tx_words  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf0      <= w_buf0_nxt;
            r_buf1      <= w_buf1_nxt;
            r_out_valid <= (w_state_nxt != TX_EMPTY);
            r_wr_ready  <= (w_state_nxt != TX_TWO);
            if (w_xfer) begin
                r_tx_words <= r_tx_words + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
